// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller; HAZARD_FORWARD_EN enables operand forwarding
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int PIPE_DEPTH   = 3,
    parameter int MISS_LATENCY = 4,
    parameter int SEL_W        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_num,
    input  logic [REG_ADDR_W-1:0] id_rt_num,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rd_num,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  branch_taken,
    input  logic                  mem_access,
    input  logic                  mem_hit,
    output logic                  stall_pc,
    output logic                  freeze_if_id,
    output logic                  flush_if_id,
    output logic                  bubble_id_exe,
    output logic                  freeze_exe,
    output logic [SEL_W-1:0]      fwd_rs_sel,
    output logic [SEL_W-1:0]      fwd_rt_sel,
    output logic                  miss_busy,
    output logic [31:0]           stall_count
);

    localparam int CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } miss_state_t;

    // Scoreboard of in-flight writers: entry 0 = EXE, 1 = MEM, 2 = WB
    logic [PIPE_DEPTH-1:0] sb_valid;
    logic [PIPE_DEPTH-1:0] sb_load;
    logic [REG_ADDR_W-1:0] sb_rd [PIPE_DEPTH];

    miss_state_t           miss_state;
    logic [CNT_W-1:0]      miss_cnt;

    logic [PIPE_DEPTH-1:0] rs_match;
    logic [PIPE_DEPTH-1:0] rt_match;
    logic                  load_use;
    logic                  hazard;
    logic                  miss_freeze;

    // Compare ID source operands against every tracked writer; r0 never matches
    always_comb begin
        rs_match = '0;
        rt_match = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            rs_match[k] = sb_valid[k] && (sb_rd[k] == id_rs_num) && (id_rs_num != '0) && id_rs_used;
            rt_match[k] = sb_valid[k] && (sb_rd[k] == id_rt_num) && (id_rt_num != '0) && id_rt_used;
        end
        load_use = (rs_match[0] | rt_match[0]) & sb_load[0];
    end

`ifdef HAZARD_FORWARD_EN
    // Youngest matching writer supplies the operand; only a load in EXE must wait
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (rs_match[k]) fwd_rs_sel = SEL_W'(k + 1);
            if (rt_match[k]) fwd_rt_sel = SEL_W'(k + 1);
        end
        hazard = load_use;
    end
`else
    // Without forwarding, any in-flight writer of a source holds ID until it retires
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        hazard     = (|rs_match) | (|rt_match) | load_use;
    end
`endif

    // Miss freeze covers the detect cycle and every MISS cycle; dropped while in reset
    always_comb begin
        miss_freeze   = !rst && ((miss_state == MISS) ||
                                 (mem_access && !mem_hit));
        stall_pc      = miss_freeze | hazard;
        freeze_if_id  = miss_freeze | hazard;
        bubble_id_exe = hazard & !miss_freeze;
        freeze_exe    = miss_freeze;
        flush_if_id   = branch_taken & !stall_pc;
    end

    // Advance the scoreboard with the pipe; hold it while the back end is frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) sb_rd[k] <= '0;
        end else if (!freeze_exe) begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            sb_valid[0] <= id_valid & id_reg_write & !bubble_id_exe & (id_rd_num != '0);
            sb_load[0]  <= id_is_load;
            sb_rd[0]    <= id_rd_num;
        end
    end

    // Miss FSM: count MISS_LATENCY cycles after a detected miss; hits are ignored meanwhile
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_state <= IDLE;
            miss_cnt   <= '0;
            miss_busy  <= 1'b0;
        end else begin
            case (miss_state)
                IDLE: begin
                    if (mem_access && !mem_hit) begin
                        miss_state <= MISS;
                        miss_cnt   <= CNT_W'(MISS_LATENCY - 1);
                        miss_busy  <= 1'b1;
                    end
                end
                MISS: begin
                    if (miss_cnt == '0) begin
                        miss_state <= IDLE;
                        miss_busy  <= 1'b0;
                    end else begin
                        miss_cnt <= miss_cnt - 1'b1;
                    end
                end
                default: begin
                    miss_state <= IDLE;
                    miss_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_pc && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (expectations follow HAZARD_FORWARD_EN)
module tb_hazard_ctrl;

    localparam int REG_ADDR_W   = 5;
    localparam int PIPE_DEPTH   = 3;
    localparam int MISS_LATENCY = 4;
    localparam int SEL_W        = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_num;
    logic [REG_ADDR_W-1:0] id_rt_num;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_rd_num;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  branch_taken;
    logic                  mem_access;
    logic                  mem_hit;
    logic                  stall_pc;
    logic                  freeze_if_id;
    logic                  flush_if_id;
    logic                  bubble_id_exe;
    logic                  freeze_exe;
    logic [SEL_W-1:0]      fwd_rs_sel;
    logic [SEL_W-1:0]      fwd_rt_sel;
    logic                  miss_busy;
    logic [31:0]           stall_count;

    hazard_ctrl #(
        .REG_ADDR_W  (REG_ADDR_W),
        .PIPE_DEPTH  (PIPE_DEPTH),
        .MISS_LATENCY(MISS_LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs_num    (id_rs_num),
        .id_rt_num    (id_rt_num),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_rd_num    (id_rd_num),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .branch_taken (branch_taken),
        .mem_access   (mem_access),
        .mem_hit      (mem_hit),
        .stall_pc     (stall_pc),
        .freeze_if_id (freeze_if_id),
        .flush_if_id  (flush_if_id),
        .bubble_id_exe(bubble_id_exe),
        .freeze_exe   (freeze_exe),
        .fwd_rs_sel   (fwd_rs_sel),
        .fwd_rt_sel   (fwd_rt_sel),
        .miss_busy    (miss_busy),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [5:0]  flags;   // stall_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_exe, miss_busy
        logic [1:0]  rs_sel;
        logic [1:0]  rt_sel;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_cnt = 0;

    // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [41:0] act, req;
            e   = exp_q.pop_front();
            act = {stall_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_exe, miss_busy,
                   fwd_rs_sel, fwd_rt_sel, stall_count};
            req = {e.flags, e.rs_sel, e.rt_sel, e.cnt};
            tests++;
            if (act !== req) begin
                fails++;
                $display("FAIL %s: flags/rs/rt/count got %b/%0d/%0d/%0d expected %b/%0d/%0d/%0d",
                         e.tag, act[41:36], act[35:34], act[33:32], act[31:0],
                         req[41:36], req[35:34], req[33:32], req[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(string tag, bit s, bit fz, bit fl, bit bub, bit fe, bit busy,
                            logic [1:0] rs, logic [1:0] rt);
        exp_t e;
        e.tag    = tag;
        e.flags  = {s, fz, fl, bub, fe, busy};
        e.rs_sel = rs;
        e.rt_sel = rt;
        e.cnt    = exp_cnt;
        exp_q.push_back(e);
        if (s) exp_cnt = exp_cnt + 1;
    endtask

    task automatic exp_none(string tag);            push_exp(tag, 0, 0, 0, 0, 0, 0, 0, 0);      endtask
    task automatic exp_stall(string tag);           push_exp(tag, 1, 1, 0, 1, 0, 0, 0, 0);      endtask
    task automatic exp_flush(string tag);           push_exp(tag, 0, 0, 1, 0, 0, 0, 0, 0);      endtask
    task automatic exp_freeze(string tag, bit b);   push_exp(tag, 1, 1, 0, 0, 1, b, 0, 0);      endtask
    task automatic exp_fwd(string tag, logic [1:0] rs, logic [1:0] rt);
        push_exp(tag, 0, 0, 0, 0, 0, 0, rs, rt);
    endtask

    task automatic set_id(int rs, int rt, bit rsu, bit rtu, int rd, bit rw, bit ld);
        id_valid     = 1'b1;
        id_rs_num    = REG_ADDR_W'(rs);
        id_rt_num    = REG_ADDR_W'(rt);
        id_rs_used   = rsu;
        id_rt_used   = rtu;
        id_rd_num    = REG_ADDR_W'(rd);
        id_reg_write = rw;
        id_is_load   = ld;
    endtask

    task automatic idle_id();
        id_valid     = 1'b0;
        id_rs_num    = '0;
        id_rt_num    = '0;
        id_rs_used   = 1'b0;
        id_rt_used   = 1'b0;
        id_rd_num    = '0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            tick();
            idle_id();
            exp_none("drain");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_id();
        branch_taken = 1'b0;
        mem_access   = 1'b0;
        mem_hit      = 1'b0;
        tick(); exp_none("reset");
        tick(); rst = 1'b0; exp_none("post_reset");

        // ADD r3 then SUB reading r3 as rs
        tick(); set_id(1, 2, 1, 1, 3, 1, 0); exp_none("add_r3");
        tick(); set_id(3, 4, 1, 1, 6, 1, 0);
`ifdef HAZARD_FORWARD_EN
        exp_fwd("sub_fwd_rs", 1, 0);
`else
        exp_stall("sub_raw_e0");
        tick(); exp_stall("sub_raw_e1");
        tick(); exp_stall("sub_raw_e2");
        tick(); exp_none("sub_release");
`endif
        drain();

        // LW r5 then ADD reading r5 as rt
        tick(); set_id(1, 0, 1, 0, 5, 1, 1); exp_none("lw_r5");
        tick(); set_id(2, 5, 1, 1, 7, 1, 0); exp_stall("ld_use");
`ifdef HAZARD_FORWARD_EN
        tick(); exp_fwd("ld_fwd_rt", 0, 2);
`else
        tick(); exp_stall("ld_raw_e1");
        tick(); exp_stall("ld_raw_e2");
        tick(); exp_none("ld_release");
`endif
        drain();

        // Taken branch alone, then coincident with a load-use stall
        tick(); idle_id(); branch_taken = 1'b1; exp_flush("br_flush");
        tick(); branch_taken = 1'b0; exp_none("br_done");
        tick(); set_id(1, 0, 1, 0, 8, 1, 1); exp_none("lw_r8");
        tick(); set_id(8, 0, 1, 0, 0, 0, 0); branch_taken = 1'b1; exp_stall("br_ld_use");
`ifdef HAZARD_FORWARD_EN
        tick(); push_exp("br_release", 0, 0, 1, 0, 0, 0, 2, 0);
`else
        tick(); exp_stall("br_raw_e1");
        tick(); exp_stall("br_raw_e2");
        tick(); exp_flush("br_release");
`endif
        tick(); branch_taken = 1'b0; idle_id(); exp_none("br_idle");
        drain();

        // Writer to r0 followed by reader of r0
        tick(); set_id(1, 2, 1, 1, 0, 1, 0); exp_none("wr_r0");
        tick(); set_id(0, 0, 1, 1, 4, 1, 0); exp_none("rd_r0");
        drain();

        // Cache miss: 1 detect + MISS_LATENCY busy cycles, hit in MISS ignored
        tick(); idle_id(); mem_access = 1'b1; mem_hit = 1'b0; exp_freeze("miss_detect", 0);
        for (int i = 0; i < MISS_LATENCY; i++) begin
            tick(); mem_hit = (i == 1); exp_freeze("miss_wait", 1);
        end
        tick(); mem_hit = 1'b1; exp_none("miss_resume");
        tick(); mem_access = 1'b0; mem_hit = 1'b0; exp_none("miss_idle");

        // Load-use coincident with a miss: freeze first, load-use after release
        tick(); set_id(1, 0, 1, 0, 9, 1, 1); exp_none("lw_r9");
        tick(); set_id(9, 0, 1, 0, 0, 0, 0); mem_access = 1'b1; mem_hit = 1'b0;
        exp_freeze("lu_miss_detect", 0);
        for (int i = 0; i < MISS_LATENCY; i++) begin
            tick(); exp_freeze("lu_miss_wait", 1);
        end
        tick(); mem_hit = 1'b1; exp_stall("lu_after_miss");
        tick(); mem_access = 1'b0; mem_hit = 1'b0;
`ifdef HAZARD_FORWARD_EN
        exp_fwd("lu_fwd", 2, 0);
`else
        exp_stall("lu_raw_e1");
        tick(); exp_stall("lu_raw_e2");
        tick(); exp_none("lu_release");
`endif
        drain();

        // Reset pulsed while the miss counter is at 2
        tick(); set_id(1, 0, 1, 0, 10, 1, 0); exp_none("add_r10");
        tick(); idle_id(); mem_access = 1'b1; mem_hit = 1'b0; exp_freeze("rst_detect", 0);
        tick(); exp_freeze("rst_cnt3", 1);
        tick(); #1 rst = 1'b1; exp_cnt = 0; exp_none("rst_mid_miss");
        tick(); rst = 1'b0; mem_access = 1'b0; set_id(10, 0, 1, 0, 0, 0, 0); exp_none("rst_sb_clear");
        tick(); idle_id(); exp_none("final");

        tick();
        tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard and stall controller for the 5-stage core (IF, ID, EXE, MEM, WB). Today every stage register has its freeze input tied low, and no forwarding or interlock exists.
- The block tracks in-flight register writers in a scoreboard of depth PIPE_DEPTH and resolves load-use and RAW hazards by forwarding or stalling.
- Freezes the whole pipe on a data-cache miss for a parametrised latency.
- Flushes IF/ID on a taken branch or jump.

Parameters:
- REG_ADDR_W, 5: register number width.
- PIPE_DEPTH, 3: number of tracked stages after ID (entry 0 = EXE, 1 = MEM, 2 = WB); must be at least 2.
- MISS_LATENCY, 4: cycles the pipe stays frozen after the detect cycle on a cache miss; must be at least 1.
- SEL_W, $clog2(PIPE_DEPTH+1): forwarding select width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_rs_num  in  REG_ADDR_W  source register rs
- id_rt_num  in  REG_ADDR_W  source register rt
- id_rs_used  in  1  instruction reads rs
- id_rt_used  in  1  instruction reads rt
- id_rd_num  in  REG_ADDR_W  final destination register (after reg_dst/jal muxing)
- id_reg_write  in  1  instruction writes the regfile
- id_is_load  in  1  instruction is LW or LB
- branch_taken  in  1  branch, jump or jr resolved taken in ID
- mem_access  in  1  MEM stage holds a cache-enabled access
- mem_hit  in  1  cache hit for that access
- stall_pc  out  1  hold PC
- freeze_if_id  out  1  hold IF/ID
- flush_if_id  out  1  clear IF/ID to NOP
- bubble_id_exe  out  1  load NOP into ID/EXE
- freeze_exe  out  1  hold ID/EXE, EXE/MEM and MEM/WB; suppress regfile write
- fwd_rs_sel  out  SEL_W  rs operand source: 0 = regfile, k+1 = result of scoreboard entry k
- fwd_rt_sel  out  SEL_W  rt operand source, same encoding
- miss_busy  out  1  miss FSM not IDLE
- stall_count  out  32  saturating count of cycles with stall_pc=1

Behaviour:
- Reset (asynchronous, rst=1):
  - Scoreboard entries all invalid; FSM in IDLE; stall_count = 0.
  - All combinational outputs evaluate to 0 while scoreboard is empty and inputs are low.
- Scoreboard, entry k = {valid, rd, is_load}:
  - Each clock edge with freeze_exe=0: entries shift k to k+1; entry PIPE_DEPTH-1 is discarded.
  - New entry 0 = {id_valid & id_reg_write & !bubble_id_exe & rd!=0, id_rd_num, id_is_load}.
  - With freeze_exe=1: all entries hold.
- Match rules:
  - match_k(src) = entry[k].valid & entry[k].rd==src & src!=0 & used.
  - Register 0 never matches.
- Forwarding:
  - Select = k+1 for the smallest matching k (youngest writer wins); 0 if no match.
  - Selects are meaningful only when no stall is asserted.
- Load-use stall: rs or rt matches entry 0 and entry 0 is a load.
  - Outputs: stall_pc=1, freeze_if_id=1, bubble_id_exe=1 for exactly one cycle.
  - Next cycle the load is in entry 1 and data is forwarded from MEM.
- Miss FSM, states IDLE and MISS:
  - IDLE to MISS: mem_access & !mem_hit; counter loads MISS_LATENCY-1.
  - MISS: counter decrements; when counter==0, return to IDLE.
  - Freeze window: detect cycle plus every MISS cycle, i.e. 1+MISS_LATENCY cycles.
  - During the window: stall_pc, freeze_if_id and freeze_exe are all 1; bubble_id_exe=0; flush_if_id=0.
  - mem_hit is ignored while in MISS.
  - In the IDLE cycle that follows, the same access must hit (cache refilled). If it misses again, a new window starts.
- Priority: miss freeze > load-use stall > flush.
  - flush_if_id = branch_taken & !stall_pc.
  - A branch that is stalled re-evaluates on the following cycle.
- Simultaneous load-use and miss: only the miss freeze is applied. The load-use check repeats after release.
- stall_count increments each cycle stall_pc=1 and saturates at 32'hFFFF_FFFF.
- Reset asserted mid-miss: FSM goes to IDLE immediately, the scoreboard clears, and freeze drops asynchronously.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: forwarding is active as above; only load-use and misses stall.
- Undefined:
  - fwd_rs_sel and fwd_rt_sel are tied to 0.
  - Any match_k for k < PIPE_DEPTH stalls, using the same output pattern as load-use.
  - The stall repeats each cycle until the writer leaves the scoreboard, because the regfile writes on the WB edge and ID reads the old value in the same cycle.

Test Plan:
- ADD r3 followed by SUB using r3 as rs, HAZARD_FORWARD_EN defined -> no stall; fwd_rs_sel=1 in the SUB's ID cycle; stall_count stays 0.
- LW r5 followed by ADD using r5 as rt -> one cycle of stall_pc=freeze_if_id=bubble_id_exe=1; next cycle fwd_rt_sel=2; stall_count=1.
- mem_access=1 and mem_hit=0 with MISS_LATENCY=4 -> freeze_exe=1 for exactly 5 cycles; miss_busy=1 for the last 4; the pipe resumes on the 6th cycle.
- branch_taken=1 with no hazards -> flush_if_id=1 for 1 cycle. branch_taken=1 coincident with a load-use stall -> flush_if_id=0 that cycle and 1 the next.
- Writer to r0 followed by a reader of r0 -> no match, fwd_sel=0, no stall. HAZARD_FORWARD_EN undefined with an ADD r3 then a dependent reader -> stall_pc held 3 cycles.
- rst pulsed during MISS count 2 -> miss_busy=0, all freezes 0, stall_count=0, scoreboard empty (the next reader sees fwd_sel=0).
